// File: rtl/tpu_bus_pkg.sv
// tpu_bus_pkg: bus master FSM states and TPU slave address map, shared with the slave decode.
package tpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_LOAD_C,
        ST_START,
        ST_WAIT,
        ST_READ_C,
        ST_DONE
    } state_t;

    localparam logic [15:0] TPU_A_BASE = 16'h0100;
    localparam logic [15:0] TPU_B_BASE = 16'h0200;
    localparam logic [15:0] TPU_C_BASE = 16'h0300;
    localparam logic [15:0] TPU_START  = 16'h0400;
    localparam logic [15:0] TPU_C_HALF = 16'h0008;

    // A/B rows sit on an 8-byte stride from their region base.
    function automatic logic [15:0] tpu_row_addr(input logic [15:0] base, input logic [7:0] idx);
        return base + 16'({idx, 3'b000});
    endfunction

    // C rows take 16 bytes: lo half at +0, hi half at +TPU_C_HALF.
    function automatic logic [15:0] tpu_c_addr(input logic [7:0] idx);
        return TPU_C_BASE + 16'({idx[7:1], 4'b0000}) + (idx[0] ? TPU_C_HALF : 16'h0000);
    endfunction

endpackage

// File: rtl/tpu_rsp_reg.sv
// tpu_rsp_reg: one-entry valid/ready result register loaded by a capture enable.
module tpu_rsp_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap_en,
    input  logic [W-1:0] cap_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // The master only captures into an empty or draining entry, so capture wins over a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (cap_en) begin
            out_valid <= 1'b1;
            out_data  <= cap_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tpu_bus_master.sv
// tpu_bus_master: runs one TPU matmul job over the slave bus (load A/B/C, START, wait, read C).
module tpu_bus_master
    import tpu_bus_pkg::*;
#(
    parameter int BITS_AB     = 8,
    parameter int BITS_C      = 16,
    parameter int DIM         = 8,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 4*DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_start,
    input  logic             load_c,
    output logic             job_busy,
    output logic             job_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             bus_rw,
    output logic [ADDRW-1:0] bus_addr,
    output logic [DATAW-1:0] bus_wdata,
    input  logic [DATAW-1:0] bus_rdata
);

    localparam int CW = $clog2(2*DIM) + 1;
    localparam int WW = $clog2(WAIT_CYCLES + 1);

    if (DIM*BITS_AB != DATAW || (DIM/2)*BITS_C != DATAW || DIM > 8) begin : g_cfg_err
        $error("tpu_bus_master: DIM/BITS_AB/BITS_C do not fit DATAW");
    end

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WW-1:0]    wcnt, wcnt_n;
    logic             load_c_q, load_c_n;
    logic             rd_pend, issue;
    logic             rw_n;
    logic [ADDRW-1:0] addr_n, row_addr, c_addr;
    logic [DATAW-1:0] wdata_n;
    logic             last_ab, last_c, all_rd;

    assign row_addr = ADDRW'(tpu_row_addr(state == ST_LOAD_A ? TPU_A_BASE : TPU_B_BASE, 8'(cnt)));
    assign c_addr   = ADDRW'(tpu_c_addr(8'(cnt)));
    assign last_ab  = cnt == CW'(DIM - 1);
    assign last_c   = cnt == CW'(2*DIM - 1);
    assign all_rd   = cnt == CW'(2*DIM);
    assign job_busy = state != ST_IDLE && state != ST_DONE;
    assign job_done = state == ST_DONE;

    // Next state, counters and the next registered bus beat; the bus idles unless a transfer is chosen.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wcnt_n   = wcnt;
        load_c_n = load_c_q;
        rw_n     = 1'b0;
        addr_n   = '0;
        wdata_n  = '0;
        in_ready = 1'b0;
        issue    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (job_start) begin
                    state_n  = ST_LOAD_A;
                    load_c_n = load_c;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rw_n    = 1'b1;
                    addr_n  = row_addr;
                    wdata_n = in_data;
                    cnt_n   = cnt + CW'(1);
                    if (last_ab) state_n = state == ST_LOAD_A ? ST_LOAD_B : ST_LOAD_C;
                end
            end
            ST_LOAD_C: begin
                in_ready = load_c_q;
                if (in_valid || !load_c_q) begin
                    rw_n    = 1'b1;
                    addr_n  = c_addr;
                    wdata_n = load_c_q ? in_data : '0;
                    cnt_n   = cnt + CW'(1);
                    if (last_c) state_n = ST_START;
                end
            end
            ST_START: begin
                rw_n    = 1'b1;
                addr_n  = ADDRW'(TPU_START);
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                wcnt_n = wcnt + WW'(1);
                if (wcnt == WW'(WAIT_CYCLES - 1)) state_n = ST_READ_C;
            end
            ST_READ_C: begin
                issue  = !all_rd && !rd_pend && (!out_valid || out_ready);
                addr_n = issue ? c_addr : '0;
                cnt_n  = cnt + CW'(issue);
                if (all_rd && !rd_pend && out_valid && out_ready) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (state_n != state) begin
            cnt_n  = '0;
            wcnt_n = '0;
        end
    end

    // State, counters and the registered bus; rd_pend marks a read whose data is on bus_rdata now.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wcnt      <= '0;
            load_c_q  <= 1'b0;
            rd_pend   <= 1'b0;
            bus_rw    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wcnt      <= wcnt_n;
            load_c_q  <= load_c_n;
            rd_pend   <= issue;
            bus_rw    <= rw_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
        end
    end

    tpu_rsp_reg #(.W(DATAW)) u_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (rd_pend),
        .cap_data  (bus_rdata),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_tpu_bus_master.sv
// tb_tpu_bus_master: drives matmul jobs against a TPU slave model and scoreboards bus writes and results.
module tb_tpu_bus_master;
    import tpu_bus_pkg::*;

    localparam int WAIT_CYCLES = 32;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
        logic        src;
    } wr_t;

    logic        clk, rst_n, job_start, load_c, job_busy, job_done;
    logic        in_valid, in_ready, out_valid, out_ready, bus_rw;
    logic [63:0] in_data, out_data, bus_wdata, bus_rdata;
    logic [15:0] bus_addr;

    tpu_bus_master #(
        .BITS_AB(8), .BITS_C(16), .DIM(8), .ADDRW(16), .DATAW(64), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start), .load_c(load_c),
        .job_busy(job_busy), .job_done(job_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0, n_bad = 0;
    int          start_cnt = 0, res_cnt = 0, done_cnt = 0, idle_n = 0, nb = 0, s_sum;
    bit          chk_idle = 0, prev_hs = 0;
    wr_t         wq[$];
    wr_t         we;
    logic [63:0] rq[$];
    logic [63:0] beats[32];
    logic [63:0] amem[8], bmem[8], cmem[16];
    int          am[8][8], bm[8][8], cm[8][8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // TPU slave model: region writes, START computes C += A*B, C readable combinationally.
    assign bus_rdata = (bus_addr[15:8] == 8'h03) ? cmem[bus_addr[6:3]] : 64'h0;

    always @(negedge clk) begin
        if (bus_rw) begin
            if (bus_addr[15:8] == 8'h01) amem[bus_addr[5:3]] = bus_wdata;
            else if (bus_addr[15:8] == 8'h02) bmem[bus_addr[5:3]] = bus_wdata;
            else if (bus_addr[15:8] == 8'h03) cmem[bus_addr[6:3]] = bus_wdata;
            else if (bus_addr == 16'h0400) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        s_sum = 0;
                        for (int m = 0; m < 8; m++) s_sum += int'(amem[r][m*8+:8]) * int'(bmem[m][c*8+:8]);
                        cmem[2*r + c/4][(c%4)*16+:16] = cmem[2*r + c/4][(c%4)*16+:16] + 16'(s_sum);
                    end
            end
        end
    end

    // Bus and result monitor: pops the write and result scoreboards, measures the WAIT gap.
    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
            rq.delete();
            chk_idle = 0;
            idle_n   = 0;
            prev_hs  = 0;
        end else begin
            if (bus_rw) begin
                if (wq.size() == 0) check("wr_extra", 64'(bus_rw), 64'd0);
                else begin
                    we = wq.pop_front();
                    check("wr_addr", 64'(bus_addr), 64'(we.addr));
                    if (we.addr != 16'h0400) check("wr_data", bus_wdata, we.data);
                    if (we.src) check("wr_hs", 64'(prev_hs), 64'd1);
                    if (we.addr == 16'h0400) begin
                        start_cnt++;
                        chk_idle = 1;
                        idle_n   = 0;
                    end
                end
            end else if (chk_idle) begin
                if (bus_addr == 16'h0) idle_n++;
                else begin
                    check("wait_idle", 64'(idle_n), 64'(WAIT_CYCLES));
                    check("first_rd", 64'(bus_addr), 64'h300);
                    chk_idle = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (rq.size() == 0) check("res_extra", 64'(out_valid), 64'd0);
                else begin
                    check("res", out_data, rq.pop_front());
                    res_cnt++;
                end
            end
            if (job_done) done_cnt++;
            prev_hs = in_valid && in_ready;
        end
    end

    task automatic check_rst();
        check("rst_rw", 64'(bus_rw), 64'd0);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_wdata", bus_wdata, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(job_busy), 64'd0);
        check("rst_done", 64'(job_done), 64'd0);
    endtask

    // pat 0: A=identity, B[i][j]=i+j, C=0; pat 1: random. Pushes expected writes and results.
    task automatic prep(input int pat, input int lc);
        logic [63:0] v;
        int          s, c;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                am[i][j] = pat == 0 ? int'(i == j) : int'($urandom_range(0, 255));
                bm[i][j] = pat == 0 ? i + j : int'($urandom_range(0, 255));
                cm[i][j] = (pat == 0 || lc == 0) ? 0 : int'($urandom_range(0, 65535));
            end
        for (int i = 0; i < 8; i++) begin
            beats[i]   = '0;
            beats[8+i] = '0;
            for (int j = 0; j < 8; j++) begin
                beats[i][j*8+:8]   = 8'(am[i][j]);
                beats[8+i][j*8+:8] = 8'(bm[i][j]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            beats[16+k] = '0;
            for (int j = 0; j < 4; j++) beats[16+k][j*16+:16] = 16'(cm[k/2][(k%2)*4+j]);
        end
        nb = lc != 0 ? 32 : 16;
        for (int i = 0; i < 8; i++) wq.push_back('{16'(256 + i*8), beats[i], 1'b1});
        for (int i = 0; i < 8; i++) wq.push_back('{16'(512 + i*8), beats[8+i], 1'b1});
        for (int k = 0; k < 16; k++) wq.push_back('{16'(768 + k*8), lc != 0 ? beats[16+k] : 64'd0, lc != 0});
        wq.push_back('{16'h0400, 64'd0, 1'b0});
        for (int k = 0; k < 16; k++) begin
            v = '0;
            for (int j = 0; j < 4; j++) begin
                c = (k%2)*4 + j;
                s = cm[k/2][c];
                for (int m = 0; m < 8; m++) s += am[k/2][m] * bm[m][c];
                v[j*16+:16] = 16'(s);
            end
            rq.push_back(v);
        end
    endtask

    // abort 1: reset in WAIT; abort 2: reset in READ_C after three results. poke holds job_start high.
    task automatic run_job(input int lc, input int stall, input int hold, input int poke, input int abort);
        int b, cyc, hs, d0, s0, r0;
        bit fin;
        d0 = done_cnt; s0 = start_cnt; r0 = res_cnt;
        b = 0; cyc = 0; hs = 0; fin = 0;
        @(posedge clk); #1;
        job_start = 1'b1;
        load_c    = lc[0];
        while (!fin && cyc < 4000) begin
            @(posedge clk); #1;
            job_start = poke[0];
            load_c    = 1'($urandom_range(0, 1));
            in_valid  = b < nb ? (stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1) : hold[0];
            in_data   = b < nb ? beats[b] : {$urandom, $urandom};
            out_ready = stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                b++;
                hs++;
            end
            cyc++;
            if (job_done) fin = 1;
            else if ((abort == 1 && start_cnt != s0) || (abort == 2 && res_cnt - r0 >= 3)) begin
                @(posedge clk); #1;
                rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; job_start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_rst();
                @(posedge clk); #1;
                rst_n = 1'b1;
                fin   = 1;
            end
        end
        check("job_timeout", 64'(fin), 64'd1);
        if (abort == 0) check("hs_cnt", 64'(hs), lc != 0 ? 64'd32 : 64'd16);
        @(posedge clk); #1;
        job_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("busy_after", 64'(job_busy), 64'd0);
        check("done_cnt", 64'(done_cnt - d0), abort != 0 ? 64'd0 : 64'd1);
        check("res_left", 64'(rq.size()), 64'd0);
        check("wr_left", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; job_start = 1'b0; load_c = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst();
        @(posedge clk); #1;
        rst_n = 1'b1;
        prep(0, 1); run_job(1, 0, 1, 0, 0);
        prep(1, 0); run_job(0, 0, 1, 0, 0);
        prep(0, 1); run_job(1, 1, 0, 0, 0);
        prep(1, 1); run_job(1, 0, 0, 0, 1);
        prep(1, 1); run_job(1, 1, 0, 0, 2);
        prep(1, 1); run_job(1, 0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
